// File: rtl/music_pkg.sv
// Shared constants for the music request scheduler:
// song table, state encoding and address width.
package music_pkg;

    localparam int AW   = 12;
    localparam int ID_W = 2;
    localparam int NSND = 4;
    localparam int SW   = 13;

    localparam logic [ID_W-1:0] SND_CLICK = 2'd0;
    localparam logic [ID_W-1:0] SND_ERROR = 2'd1;
    localparam logic [ID_W-1:0] SND_ALARM = 2'd2;
    localparam logic [ID_W-1:0] SND_BOOT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        HALT
    } state_t;

    function automatic logic [AW-1:0] song_start(
        input logic [ID_W-1:0] id
    );
        case (id)
            SND_CLICK: song_start = 12'h010;
            SND_ERROR: song_start = 12'hFFE;
            SND_ALARM: song_start = 12'h200;
            default:   song_start = 12'h100;
        endcase
    endfunction

    function automatic logic [AW-1:0] song_stop(
        input logic [ID_W-1:0] id
    );
        case (id)
            SND_CLICK: song_stop = 12'h014;
            SND_ERROR: song_stop = 12'h002;
            SND_ALARM: song_stop = 12'h200;
            default:   song_stop = 12'h108;
        endcase
    endfunction

    // Wraps modulo 4096 just like the player's program counter.
    function automatic logic [AW-1:0] song_len(
        input logic [ID_W-1:0] id
    );
        song_len = song_stop(id) - song_start(id);
    endfunction

endpackage

// File: rtl/music_scheduler_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
// Used for both request selection and preemption.
module prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/music_scheduler.sv
// Arbitrates sound requesters onto the single tone player,
// timing each song since the player reports no completion.
module music_scheduler
    import music_pkg::*;
#(
    parameter int NREQ  = NSND,
`ifdef SIMULATION
    parameter int DIV   = 100,
`else
    parameter int DIV   = 3000000,
`endif
    parameter int GUARD = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [NREQ-1:0] req,
    input  logic            cancel,
    output logic            start,
    output logic [AW-1:0]   start_addr,
    output logic [AW-1:0]   stop_addr,
    output logic            interrupt,
    output logic            busy,
    output logic [1:0]      active_id,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] aborted
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [ID_W-1:0] act_q, act_d;
    logic [SW-1:0]   step_q, step_d;
    logic [TW-1:0]   tick_q, tick_d;

    logic [ID_W-1:0] enc_idx;
    logic            enc_vld;
    logic [NREQ-1:0] act_oh;
    logic [NREQ-1:0] sel_oh;
    logic            tick;
    logic            fin;
    logic            preempt;

    prio_enc #(
        .N(NREQ),
        .W(ID_W)
    ) u_enc (
        .vec  (pend_q),
        .idx  (enc_idx),
        .valid(enc_vld)
    );

    assign act_oh  = {{(NREQ-1){1'b0}}, 1'b1} << act_q;
    assign sel_oh  = {{(NREQ-1){1'b0}}, 1'b1} << enc_idx;
    assign tick    = (tick_q == '0);
    // Last step ends on the tick that would take step_cnt to zero.
    assign fin     = tick && (step_q <= SW'(1));
    assign preempt = enc_vld && (enc_idx < act_q);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q | req;
        act_d     = act_q;
        step_d    = step_q;
        tick_d    = tick_q;
        start     = 1'b0;
        interrupt = 1'b0;
        done      = '0;
        aborted   = '0;
        unique case (state_q)
            IDLE: begin
                if (cancel) begin
                    pend_d = '0;
                end else if (enc_vld) begin
                    pend_d  = (pend_q | req) & ~sel_oh;
                    act_d   = enc_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                start   = 1'b1;
                step_d  = SW'(song_len(act_q)) + SW'(GUARD);
                tick_d  = TW'(DIV - 1);
                state_d = PLAY;
                if (cancel) begin
                    pend_d  = '0;
                    state_d = HALT;
                end
            end
            PLAY: begin
                tick_d = tick ? TW'(DIV - 1) : tick_q - TW'(1);
                if (tick && (step_q != '0)) step_d = step_q - SW'(1);
                if (fin) begin
                    done    = act_oh;
                    state_d = IDLE;
                    if (cancel) pend_d = '0;
                end else if (cancel) begin
                    pend_d  = '0;
                    state_d = HALT;
                end else if (preempt) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                interrupt = 1'b1;
                aborted   = act_oh;
                state_d   = IDLE;
                if (cancel) pend_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            act_q   <= '0;
            step_q  <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign active_id  = busy ? 2'(act_q) : 2'd0;
    assign start_addr = start ? song_start(act_q) : '0;
    assign stop_addr  = start ? song_stop(act_q) : '0;

endmodule

// File: tb/tb_music_scheduler.sv
// Scoreboard bench for music_scheduler: expected player events
// are queued as stimulus is driven and matched as they appear.
module tb_music_scheduler;

    localparam int DIV   = 4;
    localparam int GUARD = 1;

    localparam int K_START = 0;
    localparam int K_ABORT = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        int kind;
        int id;
        int cyc;
    } ev_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  req = '0;
    logic        cancel = 1'b0;
    logic        start;
    logic [11:0] start_addr;
    logic [11:0] stop_addr;
    logic        interrupt;
    logic        busy;
    logic [1:0]  active_id;
    logic [3:0]  done;
    logic [3:0]  aborted;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  q[$];

    music_scheduler #(
        .NREQ (4),
        .DIV  (DIV),
        .GUARD(GUARD)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .req       (req),
        .cancel    (cancel),
        .start     (start),
        .start_addr(start_addr),
        .stop_addr (stop_addr),
        .interrupt (interrupt),
        .busy      (busy),
        .active_id (active_id),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int tb_sa(input int id);
        case (id)
            0:       return 12'h010;
            1:       return 12'hFFE;
            2:       return 12'h200;
            default: return 12'h100;
        endcase
    endfunction

    function automatic int tb_ea(input int id);
        case (id)
            0:       return 12'h014;
            1:       return 12'h002;
            2:       return 12'h200;
            default: return 12'h108;
        endcase
    endfunction

    function automatic int dur(input int id);
        int len;
        len = (tb_ea(id) - tb_sa(id)) & 12'hFFF;
        return (len + GUARD) * DIV;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void push(input int k, input int id, input int c);
        ev_t e;
        e.kind = k;
        e.id   = id;
        e.cyc  = c;
        q.push_back(e);
    endfunction

    always @(negedge Clock) begin
        ev_t e;
        int  k;
        int  id;
        int  n;
        if (start || interrupt || (done != 0) || (aborted != 0)) begin
            n = int'(start) + $countones(done) + $countones(aborted);
            check("one_event", n, 1);
            if (start) begin
                k  = K_START;
                id = int'(active_id);
            end else if (interrupt || (aborted != 0)) begin
                k  = K_ABORT;
                id = oh_idx(aborted);
                check("int_with_abort",
                      int'(interrupt && (aborted != 0)), 1);
            end else begin
                k  = K_DONE;
                id = oh_idx(done);
            end
            if (q.size() == 0) begin
                check("unexpected_ev", k * 10 + id, -1);
            end else begin
                e = q.pop_front();
                check("ev_kind", k, e.kind);
                check("ev_id", id, e.id);
                check("ev_cycle", cyc, e.cyc);
                check("ev_active_id", int'(active_id), e.id);
                if (k == K_START) begin
                    check("start_addr", int'(start_addr), tb_sa(e.id));
                    check("stop_addr", int'(stop_addr), tb_ea(e.id));
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic pulse_req(input logic [3:0] v);
        req = v;
        @(posedge Clock);
        #1;
        req = '0;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
        check("queue_drained", q.size(), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, int'(start), 0);
        check({tag, "_int"}, int'(interrupt), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_aid"}, int'(active_id), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_abort"}, int'(aborted), 0);
        check({tag, "_saddr"}, int'(start_addr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int s;
        int d;

        repeat (3) @(posedge Clock);
        #1;
        check_zero("reset");
        Reset = 1'b1;

        // Single request for song 3
        wait_cyc(10);
        t0 = cyc;
        push(K_START, 3, t0 + 2);
        push(K_DONE, 3, t0 + 2 + dur(3));
        pulse_req(4'b1000);
        wait_cyc(t0 + 3);
        check("single_busy", int'(busy), 1);
        check("single_aid", int'(active_id), 3);
        wait_cyc(t0 + 2 + dur(3) + 1);
        check("single_busy_after", int'(busy), 0);
        quiet(10);

        // Song 0 preempts song 3, which is not replayed
        t0 = cyc;
        s  = t0 + 2;
        push(K_START, 3, s);
        pulse_req(4'b1000);
        wait_cyc(s + 10);
        push(K_ABORT, 3, s + 12);
        push(K_START, 0, s + 14);
        push(K_DONE, 0, s + 14 + dur(0));
        pulse_req(4'b0001);
        quiet(60);

        // Queueing and merge behind song 0; covers wrap and zero length
        t0 = cyc;
        s  = t0 + 2;
        d  = s + dur(0);
        push(K_START, 0, s);
        push(K_DONE, 0, d);
        push(K_START, 1, d + 2);
        push(K_DONE, 1, d + 2 + dur(1));
        push(K_START, 2, d + 4 + dur(1));
        push(K_DONE, 2, d + 4 + dur(1) + dur(2));
        pulse_req(4'b0001);
        wait_cyc(t0 + 5);
        pulse_req(4'b0100);
        pulse_req(4'b0010);
        pulse_req(4'b0010);
        quiet(70);

        // Cancel in PLAY beats a same-cycle request
        t0 = cyc;
        s  = t0 + 2;
        push(K_START, 3, s);
        pulse_req(4'b1000);
        wait_cyc(s + 6);
        push(K_ABORT, 3, s + 7);
        cancel = 1'b1;
        req    = 4'b0010;
        @(posedge Clock);
        #1;
        cancel = 1'b0;
        req    = '0;
        wait_cyc(s + 8);
        check("cancel_busy", int'(busy), 0);
        quiet(40);

        // Cancel while idle flushes a pending request
        pulse_req(4'b0100);
        cancel = 1'b1;
        @(posedge Clock);
        #1;
        cancel = 1'b0;
        check("idle_cancel_busy", int'(busy), 0);
        quiet(30);

        // Asynchronous reset in the middle of a song
        t0 = cyc;
        push(K_START, 3, t0 + 2);
        pulse_req(4'b1000);
        wait_cyc(t0 + 12);
        check("pre_reset_busy", int'(busy), 1);
        #2;
        Reset = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        quiet(60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/music_scheduler.md
Name: music_scheduler

Overview:
Shares the single Music tone player between NREQ sound requesters, such as key click, error tone, alarm and startup melody. Pending requests are latched and served by fixed priority, with preemption. The block drives the player's start/start_addr/stop_addr/interrupt inputs. The player gives no completion signal, so the block times each playback itself and reports done/aborted per requester. It sits between the calculator control logic and Music.

Parameters:
NREQ, 4, number of requesters; index 0 has the highest priority.
DIV, 3000000 (100 under SIMULATION), clock cycles per ROM step; must equal the Music div.
GUARD, 1, extra steps waited after the nominal song length before declaring done.

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous active-low reset
req  input  NREQ  one-cycle request pulse per requester
cancel  input  1  stop playback and flush all pending requests
start  output  1  one-cycle pulse to Music.start
start_addr  output  12  song first address, valid while start=1
stop_addr  output  12  song bound address, valid while start=1
interrupt  output  1  one-cycle pulse to Music.interrupt
busy  output  1  high in every state except IDLE
active_id  output  2  index of the song playing; 0 when idle
done  output  NREQ  one-cycle pulse when a song completes normally
aborted  output  NREQ  one-cycle pulse when a song is preempted or cancelled

Behaviour:
- Reset: all outputs 0, pending mask 0, state IDLE, counters 0. Reset mid-song abandons it silently with no done/aborted pulse.
- Pending mask: a req[i] pulse sets pend[i]. A duplicate req for an already pending song merges into it. A req for the currently playing song sets pend[i], so the song replays after it finishes; it does not restart the current playback.
- Song table: SONG_START[i] and SONG_STOP[i] are constants. len = (SONG_STOP - SONG_START) mod 4096, 12-bit wraparound, matching the player's pc wrap.
- States:
  - IDLE: if pend != 0, select the lowest set index, clear its pend bit, go to LOAD.
  - LOAD: start=1, addresses driven, active_id=sel. Load step_cnt = len + GUARD (13 bits) and tick_cnt = DIV-1. Go to PLAY.
  - PLAY: tick_cnt decrements each cycle. When tick_cnt hits 0 it reloads DIV-1 and step_cnt decrements. When step_cnt = 0 and a tick occurs, pulse done[active_id] and go to IDLE. A song with len=0 still waits GUARD steps.
  - Preemption in PLAY: if any pend[j] has j < active_id, go to HALT.
  - HALT: interrupt=1, aborted[active_id]=1. Then go to IDLE, which picks j on the next cycle.
- cancel, in any non-IDLE state: next cycle interrupt=1, aborted[active_id]=1, pend cleared, go to IDLE. cancel in IDLE clears pend only.
- Same-cycle events: cancel beats req, so same-cycle reqs are dropped. A completion tick beats preemption: done is pulsed, and the preempting request starts from IDLE.
- Output rules: start and interrupt are never high in the same cycle. There are at least 2 cycles between an interrupt and the following start.
- Timing: request-to-start latency from IDLE is 2 cycles (pulse at cycle t, pend set at t+1, IDLE select, LOAD/start high at t+2). Only one done or aborted bit is high per cycle.
- Tick phase: the player's divider is free-running and not aligned with start. Actual playback ends within one step of len, and GUARD covers that skew.

Decomposition:
- Package music_pkg holds:
  - SONG_START/SONG_STOP arrays and song index constants (SND_CLICK=0 … SND_BOOT=3);
  - the state enum (IDLE, LOAD, PLAY, HALT);
  - the address width constant 12.
- Sub-module: prio_enc (NREQ-bit lowest-index priority encoder with valid flag), also used by the preemption compare. The tick counter is inline.

Test Plan:
Common setup: DIV=4, GUARD=1, SONG0 = 0x010→0x014 (len 4), SONG3 = 0x100→0x108 (len 8).
- Single request: req[3] at cycle 10 -> start=1 at cycle 12 with start_addr=0x100, stop_addr=0x108; done[3] at cycle 12+9*4; busy low the cycle after.
- Preemption: req[3], then req[0] 10 cycles after start -> interrupt pulse with aborted[3]; start with start_addr=0x010 exactly 2 cycles after the interrupt; done[0] 20 cycles after that start; song 3 not replayed.
- Queueing/merge: req[2], req[1], req[1] in 3 consecutive cycles while song 0 plays -> after done[0], song 1 plays once, then song 2; no aborted pulses.
- Cancel: cancel during PLAY with req[1] in the same cycle -> interrupt, aborted[active_id], pend=0, IDLE; song 1 never starts.
- Wraparound and zero length: song with start 0xFFE, stop 0x002 -> done after (4+1)*4 cycles; song with start = stop -> done after GUARD*4 cycles.
- Reset mid-PLAY: assert Reset asynchronously -> all outputs 0 immediately; no done/aborted pulse after release.
